// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter for the integer register file.
// Picks one writeback source per cycle, registers its write and drops writes to x0.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_lock,
  output logic [AW-1:0]      addr_p2,
  output logic               we_p2,
  output logic [DW-1:0]      din_p2,
  output logic [2:0]         grant_id,
  output logic               wr_x0_drop,
  output logic [15:0]        wr_count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 16;

  logic [PW-1:0] ptr_q,  ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q,   we_d;
  logic          drop_q, drop_d;
  logic [2:0]    gid_q,  gid_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];
  logic          any_c;
  logic          accept_c;
  logic [PW-1:0] win_c;
  logic [PW:0]   cand_c;

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // First valid requester scanning from ptr upward, modulo NREQ.
  always_comb begin
    any_c  = 1'b0;
    win_c  = '0;
    cand_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_c = (PW+1)'(ptr_q) + (PW+1)'(k);
      if (cand_c >= (PW+1)'(NREQ)) begin
        cand_c = cand_c - (PW+1)'(NREQ);
      end
      if (!any_c && req_valid[cand_c[PW-1:0]]) begin
        any_c = 1'b1;
        win_c = cand_c[PW-1:0];
      end
    end
  end

  // Reset masks the grant so nothing is accepted during the reset cycle.
  always_comb begin
    accept_c  = any_c && !reset;
    req_ready = '0;
    if (accept_c) begin
      req_ready[win_c] = 1'b1;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    drop_d = 1'b0;
    if (accept_c) begin
      addr_d = addr_arr[win_c];
      data_d = data_arr[win_c];
      gid_d  = 3'(win_c);
      if (req_lock[win_c]) begin
        ptr_d = win_c;
      end else if (win_c == PW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_c + PW'(1);
      end
      // x0 is hardwired to zero: the write is consumed but never reaches the file.
      if (addr_arr[win_c] != '0) begin
        we_d  = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      drop_q <= 1'b0;
      gid_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      drop_q <= drop_d;
      gid_q  <= gid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_p2    = addr_q;
  assign din_p2     = data_q;
  assign we_p2      = we_q;
  assign wr_x0_drop = drop_q;
  assign grant_id   = gid_q;
  assign wr_count   = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the integer architectural register file (`ArchRegistersInt`). It shares the file's single write port (`addr_p2`/`we_p2`/`din_p2`) among NREQ writeback sources (ALU, load unit, CSR/mul-div) using a valid/ready handshake and round-robin priority. A per-requester lock lets a source keep the port for back-to-back writes. Accepted writes are registered and presented to the register file one cycle later; writes to x0 are accepted and discarded.

## Interface

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i's write is accepted this cycle (one-hot or zero)
- req_addr  in  NREQ*AW  destination register of requester i, bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data of requester i, bits [i*DW +: DW]
- req_lock  in  NREQ  requester i requests to keep priority after this grant
- addr_p2  out  AW  register file write address
- we_p2  out  1  register file write enable
- din_p2  out  DW  register file write data
- grant_id  out  3  index of the requester whose write is on the port this cycle (valid when we_p2 or wr_x0_drop)
- wr_x0_drop  out  1  pulse: the registered write targeted x0 and was suppressed
- wr_count  out  16  number of non-x0 writes committed since reset, wraps at 0xFFFF -> 0

## Operation

- State: round-robin pointer `ptr` (0..NREQ-1), output register {addr_p2, din_p2, we_p2, grant_id, wr_x0_drop}, wr_count.
- Arbitration (combinational, every cycle): the winner is the first i with req_valid[i] set, scanning ptr, ptr+1, … modulo NREQ. req_ready[winner]=1; all others 0. No valid → req_ready=0.
- A write is accepted when req_valid[i] && req_ready[i]. The port never back-pressures, so at most one write is accepted per cycle and exactly one whenever any valid is high.
- Pointer update on acceptance by i: if req_lock[i]=1, ptr←i (i keeps top priority next cycle); otherwise ptr←(i+1) mod NREQ. No acceptance → ptr holds. req_lock without a grant has no effect.
- Output register on acceptance: addr_p2←req_addr[i], din_p2←req_data[i], grant_id←i; if req_addr[i]!=0 then we_p2←1, wr_x0_drop←0, wr_count←wr_count+1; else we_p2←0, wr_x0_drop←1, wr_count unchanged.
- No acceptance: we_p2←0, wr_x0_drop←0; addr_p2, din_p2 and grant_id hold their previous values.
- Requesters must hold req_addr/req_data stable while req_valid is high and not yet accepted; valid may drop without acceptance (squash) with no side effect.

## Timing

- Reset (synchronous, any cycle including mid-burst): ptr=0, addr_p2=0, din_p2=0, we_p2=0, grant_id=0, wr_x0_drop=0, wr_count=0. req_ready is forced to 0 during the reset cycle; a write presented in that cycle is not accepted and does not appear on the port.
- Grant latency: 0 cycles (req_ready is combinational from req_valid and ptr).
- Write latency: accepted at edge N, we_p2/addr_p2/din_p2 valid during cycle N+1 and written into the register file at edge N+1.
- Throughput: 1 write per cycle sustained.
- Simultaneous valids: resolved only by ptr; with all NREQ requesters continuously valid and no lock, grants rotate i, i+1, … with no requester waiting more than NREQ-1 cycles.
- Locked requester continuously valid with lock=1 starves the others by design; lock deassertion on its last write releases the port in the next cycle.
- wr_count wraps 0xFFFF→0x0000 with no flag.

## Test plan

- Reset then single write: req 1 valid, addr=1 (ra), data=0xA5A5A5A5 → req_ready=3'b010 the same cycle; next cycle we_p2=1, addr_p2=1, din_p2=0xA5A5A5A5, grant_id=1; wr_count=1.
- Round-robin: all three valid for 6 cycles, no lock, ptr=0 → grant order 0,1,2,0,1,2; we_p2 high 6 consecutive cycles; read back via dout_p0 matches each last-written value.
- Lock: req 2 valid+lock for 3 cycles alongside reqs 0,1 → grants 2,2,2; lock dropped on the 3rd → next grants 0,1.
- x0 filter: req 0 writes addr=0, data=0xDEADBEEF → req_ready[0]=1, next cycle we_p2=0, wr_x0_drop=1, wr_count unchanged; register 0 reads 0.
- Reset mid-burst: reset asserted while reqs 0 and 1 valid → in that cycle req_ready=0; next cycle all outputs at reset values, ptr=0, so req 0 wins first after reset release.
- Counter wrap: preload via 65535 writes to addr=2 → wr_count=0xFFFF; one more → 0x0000.
